// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   if_id_t       : IF/ID pipeline record (also the fetch buffer entry)
//   NOP_INST      : IR value loaded for bubbles (addi x0,x0,0)
//   RESET_PC_DEFAULT : default first fetch address
package if_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_id_t;

  // Turn an IF/ID record into a bubble: PC/NPC are kept so ID still sees a
  // sensible PC, only IR and valid change.
  function automatic if_id_t make_bubble(if_id_t cur);
    if_id_t b;
    b       = cur;
    b.ir    = NOP_INST;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// One-entry skid buffer holding a fetched instruction that IF/ID could not
// take because ID was stalled.
//   clk, rst : clock, async active-low reset
//   load     : capture din (response that could not go to IF/ID)
//   drain    : entry consumed by IF/ID this cycle
//   flush    : redirect, discard entry (wins over load/drain)
//   din      : incoming record
//   valid    : entry held
//   dout     : held record
module fetch_buffer
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   flush,
  input  if_id_t din,
  output logic   valid,
  output if_id_t dout
);

  logic   valid_q, valid_d;
  if_id_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Owns the PC, keeps at most one instruction-memory
// request outstanding (req/gnt/rvalid handshake) and loads the IF/ID register.
//   clk, rst          : clock, async active-low reset
//   stall             : ID cannot take a new instruction (IF/ID holds if valid)
//   ex_take_branch    : taken branch/jump from EX, redirects to ex_target_pc
//   imem_req/addr     : fetch request and word-aligned address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : fetch response
//   if_id_*           : IF/ID register contents
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       ifid_q, ifid_d;
  if_id_t       rsp, buf_dout;
  logic         buf_valid, buf_load, buf_drain;
  logic         accept, rsp_take, to_ifid, fire;

  assign accept   = !stall || !ifid_q.valid;
  // A response in WAIT is real unless a redirect squashes it this cycle.
  assign rsp_take = (state_q == WAIT) && imem_rvalid && !ex_take_branch;
  // pc_q already moved past the outstanding request, so it is the NPC.
  assign rsp      = '{ir: imem_rdata, pc: pc_q - 32'd4, npc: pc_q, valid: 1'b1};
  // Requests are only issued with the buffer empty, so in WAIT it is empty.
  assign to_ifid  = rsp_take && !buf_valid && accept;
  assign buf_load  = rsp_take && (buf_valid || !accept);
  assign buf_drain = accept && buf_valid && !ex_take_branch;
  assign fire      = imem_req && imem_gnt;

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .drain (buf_drain),
    .flush (ex_take_branch),
    .din   (rsp),
    .valid (buf_valid),
    .dout  (buf_dout)
  );

  // Request: fresh fetch from IDLE, or back-to-back in the cycle a response
  // goes straight into IF/ID.
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      IDLE:    imem_req = !buf_valid;
      WAIT:    imem_req = to_ifid;
      default: imem_req = 1'b0;
    endcase
    if (ex_take_branch || !rst) imem_req = 1'b0;
  end

  assign imem_addr = pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fire) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)         state_d = fire ? WAIT : IDLE;
        else if (ex_take_branch) state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (ex_take_branch) pc_d = ex_target_pc & 32'hFFFF_FFFC;
    else if (fire)      pc_d = pc_q + 32'd4;
  end

  // Buffered data is older than any same-cycle response, so it goes first.
  always_comb begin
    ifid_d = ifid_q;
    if (ex_take_branch) begin
      ifid_d = make_bubble(ifid_q);
    end else if (accept) begin
      if (buf_valid)    ifid_d = buf_dout;
      else if (to_ifid) ifid_d = rsp;
      else              ifid_d = make_bubble(ifid_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      ifid_q  <= '{ir: NOP_INST, pc: 32'd0, npc: 32'd0, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign if_id_IR         = ifid_q.ir;
  assign if_id_PC         = ifid_q.pc;
  assign if_id_NPC        = ifid_q.npc;
  assign if_id_valid_inst = ifid_q.valid;

endmodule
